// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: oversampled 8N1 UART receiver feeding a byte FIFO.
// Ports:
//   ser_clk_4x    sole clock, all state updates on its rising edge
//   rst_n         asynchronous active-low reset
//   SER_RX        serial line, idles high, asynchronous to the clock
//   rd_data       FIFO head byte, 0 when the FIFO is empty
//   rd_valid      FIFO holds at least one byte
//   rd_ready      consumer accepts the head byte this cycle
//   fifo_count    number of bytes held
//   frame_err     sticky, a stop bit was sampled low
//   overrun       sticky, a byte arrived while the FIFO was full
//   err_clear     one-cycle pulse clearing both sticky flags
module uart_rx_buffered #(
    parameter int CLOCKS_PER_BIT = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          ser_clk_4x,
    input  logic                          rst_n,
    input  logic                          SER_RX,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          err_clear
);

    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    logic          sync1_q;
    logic          sync2_q;
    logic          rx_s;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;

    logic          tick;
    logic          stop_tick;
    logic          push;
    logic          ferr_set;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          full;
    logic          empty;
    logic          do_pop;
    logic          do_push;
    logic          ovr_set;

    always_ff @(posedge ser_clk_4x or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= SER_RX;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    // cnt_q restarts on entering START so the first sample lands
    // half a bit in; later samples are one full bit apart.
    assign tick      = (cnt_q == FULL_M1);
    assign stop_tick = (state_q == ST_STOP) && tick;
    assign push      = stop_tick && rx_s;
    assign ferr_set  = stop_tick && !rx_s;

    always_ff @(posedge ser_clk_4x or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_q <= ST_START;
                        cnt_q   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_DATA;
                            bit_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        cnt_q   <= '0;
                        state_q <= rx_s ? ST_IDLE : ST_BREAK;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign do_pop  = rd_ready && !empty;
    // A simultaneous pop frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign ovr_set = push && full && !do_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A set in the same cycle wins over err_clear.
        ferr_d = ferr_set || (ferr_q && !err_clear);
        ovr_d  = ovr_set || (ovr_q && !err_clear);
    end

    always_ff @(posedge ser_clk_4x or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= shift_q;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    assign rd_valid   = !empty;
    assign rd_data    = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign fifo_count = count_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb_uart_rx_buffered: self-checking bench for uart_rx_buffered.
// Drives 8N1 frames and compares received bytes and flags to a queue model.
module tb_uart_rx_buffered;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ser_rx;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [2:0] fifo_count;
    logic       frame_err;
    logic       overrun;
    logic       err_clear;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] got [$];
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    uart_rx_buffered #(
        .CLOCKS_PER_BIT(CPB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .ser_clk_4x(clk),
        .rst_n(rst_n),
        .SER_RX(ser_rx),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .fifo_count(fifo_count),
        .frame_err(frame_err),
        .overrun(overrun),
        .err_clear(err_clear)
    );

    // Consumer: inputs change on negedge, so #1 later shows what the
    // next posedge will act on.
    always begin
        @(negedge clk);
        #1;
        if (rd_valid && rd_ready) got.push_back(rd_data);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        ser_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ser_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        ser_rx = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        ser_rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic drain();
        rd_ready = 1'b1;
        repeat (DEPTH + 2) @(negedge clk);
        rd_ready = 1'b0;
        got.delete();
    endtask

    task automatic test_reset();
        n_checks++;
        if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_valid: got %b want 0", rd_valid);
        end
        n_checks++;
        if (rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_data: got %h want 00", rd_data);
        end
        n_checks++;
        if (fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_count: got %0d want 0", fifo_count);
        end
        n_checks++;
        if ({frame_err, overrun} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_flags: got %b want 00", {frame_err, overrun});
        end
    endtask

    task automatic test_single();
        rd_ready = 1'b0;
        send_byte(8'h48, 1'b1);
        n_checks++;
        if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_early: rd_valid got %b want 0 at T+38", rd_valid);
        end
        @(negedge clk);
        n_checks++;
        if (rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL t1_valid: got %b want 1 at T+39", rd_valid);
        end
        n_checks++;
        if (rd_data !== 8'h48) begin
            n_fail++;
            $display("FAIL t1_data: got %h want 48", rd_data);
        end
        n_checks++;
        if (fifo_count !== 3'd1) begin
            n_fail++;
            $display("FAIL t1_count: got %0d want 1", fifo_count);
        end
        n_checks++;
        if ({frame_err, overrun} !== 2'b00) begin
            n_fail++;
            $display("FAIL t1_flags: got %b want 00", {frame_err, overrun});
        end
        drain();
        n_checks++;
        if (rd_data !== 8'h00 || fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL t1_empty: data %h count %0d want 00 0",
                     rd_data, fifo_count);
        end
    endtask

    task automatic test_glitch();
        rd_ready = 1'b0;
        ser_rx = 1'b0;
        @(negedge clk);
        ser_rx = 1'b1;
        repeat (50) @(negedge clk);
        n_checks++;
        if (fifo_count !== 3'd0 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL t2_count: got %0d/%b want 0/0", fifo_count, rd_valid);
        end
        n_checks++;
        if (frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL t2_ferr: got %b want 0", frame_err);
        end
        send_byte(8'h3C, 1'b1);
        idle_bits(2);
        n_checks++;
        if (fifo_count !== 3'd1 || rd_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL t2_after: count %0d data %h want 1 3c",
                     fifo_count, rd_data);
        end
        drain();
    endtask

    task automatic test_frame_err();
        rd_ready = 1'b0;
        send_byte(8'h55, 1'b0);
        ser_rx = 1'b0;
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        n_checks++;
        if (frame_err !== 1'b1) begin
            n_fail++;
            $display("FAIL t3_set_prio: frame_err got %b want 1", frame_err);
        end
        repeat (9 * CPB) @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        n_checks++;
        if (frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_clear: frame_err got %b want 0", frame_err);
        end
        repeat (10 * CPB) @(negedge clk);
        n_checks++;
        if (frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_once: frame_err got %b want 0", frame_err);
        end
        n_checks++;
        if (fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL t3_dropped: count got %0d want 0", fifo_count);
        end
        idle_bits(2);
        got.delete();
        rd_ready = 1'b1;
        send_byte(8'h21, 1'b1);
        idle_bits(2);
        rd_ready = 1'b0;
        n_checks++;
        if (got.size() != 1 || got[0] !== 8'h21) begin
            n_fail++;
            $display("FAIL t3_next: got %0d bytes first %h want 1 21",
                     got.size(), (got.size() > 0) ? got[0] : 8'hxx);
        end
        n_checks++;
        if (frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_final: frame_err got %b want 0", frame_err);
        end
        got.delete();
    endtask

    task automatic test_overrun();
        logic [7:0] msg [5];
        msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(msg[i], 1'b1);
        idle_bits(2);
        n_checks++;
        if (fifo_count !== 3'd4) begin
            n_fail++;
            $display("FAIL t4_count: got %0d want 4", fifo_count);
        end
        n_checks++;
        if (overrun !== 1'b1 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL t4_flags: ovr %b ferr %b want 1 0", overrun, frame_err);
        end
        got.delete();
        rd_ready = 1'b1;
        repeat (6) @(negedge clk);
        rd_ready = 1'b0;
        n_checks++;
        if (got.size() != 4) begin
            n_fail++;
            $display("FAIL t4_pops: got %0d bytes want 4", got.size());
        end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== msg[i]) begin
                n_fail++;
                $display("FAIL t4_byte%0d: got %h want %h", i, got[i], msg[i]);
            end
        end
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        n_checks++;
        if (overrun !== 1'b0 || fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL t4_clear: ovr %b count %0d want 0 0",
                     overrun, fifo_count);
        end
        got.delete();
    endtask

    task automatic test_back_to_back();
        logic [7:0] msg [8];
        msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21, 8'h21, 8'h0A};
        got.delete();
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_byte(msg[i], 1'b1);
        idle_bits(2);
        rd_ready = 1'b0;
        n_checks++;
        if (got.size() != 8) begin
            n_fail++;
            $display("FAIL t5_size: got %0d bytes want 8", got.size());
        end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== msg[i]) begin
                n_fail++;
                $display("FAIL t5_byte%0d: got %h want %h", i, got[i], msg[i]);
            end
        end
        n_checks++;
        if ({frame_err, overrun} !== 2'b00) begin
            n_fail++;
            $display("FAIL t5_flags: got %b want 00", {frame_err, overrun});
        end
        got.delete();
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0] part;
        part = 8'h96;
        rd_ready = 1'b0;
        send_byte(8'hA5, 1'b1);
        idle_bits(1);
        send_byte(8'h0F, 1'b0);
        idle_bits(2);
        ser_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            ser_rx = part[i];
            repeat (CPB) @(negedge clk);
        end
        ser_rx = part[3];
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        ser_rx = 1'b1;
        #1;
        n_checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00 || fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL t6_fifo: valid %b data %h count %0d want 0 00 0",
                     rd_valid, rd_data, fifo_count);
        end
        n_checks++;
        if ({frame_err, overrun} !== 2'b00) begin
            n_fail++;
            $display("FAIL t6_flags: got %b want 00", {frame_err, overrun});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_bits(1);
        got.delete();
        rd_ready = 1'b1;
        send_byte(8'hC3, 1'b1);
        idle_bits(2);
        rd_ready = 1'b0;
        n_checks++;
        if (got.size() != 1 || got[0] !== 8'hC3) begin
            n_fail++;
            $display("FAIL t6_next: got %0d bytes first %h want 1 c3",
                     got.size(), (got.size() > 0) ? got[0] : 8'hxx);
        end
        got.delete();
    endtask

    task automatic test_random_stream();
        logic [7:0] b;
        exp_q.delete();
        got.delete();
        rd_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_byte(b, 1'b1);
            idle_bits(int'($urandom_range(0, 2)));
        end
        idle_bits(2);
        rd_ready = 1'b0;
        n_checks++;
        if (got.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rnd_size: got %0d bytes want %0d",
                     got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rnd_byte%0d: got %h want %h", i, got[i], exp_q[i]);
            end
        end
        n_checks++;
        if ({frame_err, overrun} !== 2'b00) begin
            n_fail++;
            $display("FAIL rnd_flags: got %b want 00", {frame_err, overrun});
        end
        got.delete();
    endtask

    task automatic test_random_overrun();
        logic [7:0] b;
        int n;
        int keep;
        for (int r = 0; r < 3; r++) begin
            n = int'($urandom_range(1, 7));
            keep = (n < DEPTH) ? n : DEPTH;
            exp_q.delete();
            rd_ready = 1'b0;
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom_range(0, 255));
                if (i < DEPTH) exp_q.push_back(b);
                send_byte(b, 1'b1);
            end
            idle_bits(2);
            n_checks++;
            if (fifo_count !== 3'(keep)) begin
                n_fail++;
                $display("FAIL rov_count: got %0d want %0d", fifo_count, keep);
            end
            n_checks++;
            if (overrun !== (n > DEPTH)) begin
                n_fail++;
                $display("FAIL rov_flag: got %b want %b", overrun, n > DEPTH);
            end
            got.delete();
            rd_ready = 1'b1;
            repeat (DEPTH + 2) @(negedge clk);
            rd_ready = 1'b0;
            n_checks++;
            if (got.size() != keep) begin
                n_fail++;
                $display("FAIL rov_size: got %0d want %0d", got.size(), keep);
            end
            for (int i = 0; i < keep && i < got.size(); i++) begin
                n_checks++;
                if (got[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rov_byte%0d: got %h want %h",
                             i, got[i], exp_q[i]);
                end
            end
            err_clear = 1'b1;
            @(negedge clk);
            err_clear = 1'b0;
            got.delete();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        ser_rx    = 1'b1;
        rd_ready  = 1'b0;
        err_clear = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        idle_bits(1);
        test_single();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_reset_mid_byte();
        test_random_stream();
        test_random_overrun();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
